// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit with HI/LO registers.
// Ports: Clk, Reset(async low), Start, MDOp, A, B, RdSel -> Busy, Out.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        RdSel,
    output logic        Busy,
    output logic [31:0] Out
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] s_hi;
    logic [31:0] s_lo;
    logic        s_wr;

    logic        idle_start;
    logic        launch;
    logic        sgn;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] dvs_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign idle_start = (state == IDLE) && Start;
    assign launch     = idle_start && !MDOp[2];
    assign sgn        = !MDOp[0];
    assign is_div     = MDOp[1];

    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

    // Signed divide on magnitudes; 0x80000000 keeps its magnitude as an
    // unsigned value, so the overflow case needs no special handling.
    assign dvd      = (sgn && A[31]) ? -A : A;
    assign dvs      = (sgn && B[31]) ? -B : B;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign q_mag    = dvd / dvs_safe;
    assign r_mag    = dvd % dvs_safe;
    assign quo      = (sgn && (A[31] ^ B[31])) ? -q_mag : q_mag;
    assign rem      = (sgn && A[31]) ? -r_mag : r_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (is_div) begin
            res_hi = rem;
            res_lo = quo;
        end else if (sgn) begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
        end else begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (launch) state_nxt = RUN;
            RUN:  if (cnt == 4'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            s_hi  <= 32'd0;
            s_lo  <= 32'd0;
            s_wr  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                s_hi <= res_hi;
                s_lo <= res_lo;
                // Divide by zero runs full length but leaves HI/LO alone.
                s_wr <= is_div ? (B != 32'd0) : 1'b1;
                cnt  <= is_div ? DIV_N : MULT_N;
            end else if (idle_start && MDOp == 3'd4) begin
                hi <= A;
            end else if (idle_start && MDOp == 3'd5) begin
                lo <= A;
            end
            if (state == RUN) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1 && s_wr) begin
                    hi <= s_hi;
                    lo <= s_lo;
                end
            end
        end
    end

    assign Busy = (state == RUN);
    assign Out  = RdSel ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and random checks of md_unit against a
// behavioural HI/LO model.
module tb_md_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        RdSel;
    logic        Busy;
    logic [31:0] Out;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .RdSel(RdSel), .Busy(Busy), .Out(Out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        RdSel = 1'b0;
        #1 chk({tag, "_lo"}, Out, m_lo);
        RdSel = 1'b1;
        #1 chk({tag, "_hi"}, Out, m_hi);
    endtask

    // Reference result from the arithmetic rules, using 64-bit integers.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] nh,
                         output logic [31:0] nl);
        longint          p;
        longint          x;
        longint          y;
        longint          q;
        longint          r;
        longint unsigned pu;
        nh = m_hi;
        nl = m_lo;
        case (op)
            3'd0: begin
                p = longint'(signed'(a)) * longint'(signed'(b));
                nh = p[63:32];
                nl = p[31:0];
            end
            3'd1: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                nh = pu[63:32];
                nl = pu[31:0];
            end
            3'd2: if (b != 0) begin
                x = longint'(signed'(a));
                y = longint'(signed'(b));
                q = x / y;
                r = x % y;
                nl = q[31:0];
                nh = r[31:0];
            end
            3'd3: if (b != 0) begin
                nl = a / b;
                nh = a % b;
            end
            3'd4: nh = a;
            3'd5: nl = a;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] nh;
        logic [31:0] nl;
        int          n;
        model(op, a, b, nh, nl);
        @(negedge Clk);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(negedge Clk);
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        n = (op < 3'd2) ? 5 : (op < 3'd4) ? 10 : 0;
        for (int i = 0; i < n; i++) begin
            RdSel = 1'($urandom);
            #1;
            chk("busy_hi", 32'(Busy), 32'd1);
            chk("hold", Out, RdSel ? m_hi : m_lo);
            @(negedge Clk);
        end
        m_hi = nh;
        m_lo = nl;
        #1 chk("busy_lo", 32'(Busy), 32'd0);
        chk_out("result");
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        MDOp  = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        RdSel = 1'b0;
        #12;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk_out("rst");
        @(negedge Clk);
        Reset = 1'b1;

        do_op(3'd0, 32'hFFFFFFFF, 32'd2);
        chk("t1_lo", m_lo, 32'hFFFFFFFE);
        do_op(3'd1, 32'hFFFFFFFF, 32'd2);
        chk("t2_hi", m_hi, 32'h00000001);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2);
        chk("t3_lo", m_lo, 32'hFFFFFFFD);
        chk("t3_hi", m_hi, 32'hFFFFFFFF);
        do_op(3'd3, 32'd7, 32'd0);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("ovf_lo", m_lo, 32'h80000000);
        do_op(3'd4, 32'h12345678, 32'd0);
        do_op(3'd5, 32'h9ABCDEF0, 32'd0);
        do_op(3'd6, 32'hDEADBEEF, 32'd1);

        // Start during RUN must be ignored.
        begin
            logic [31:0] nh;
            logic [31:0] nl;
            model(3'd2, 32'd100, 32'd7, nh, nl);
            @(negedge Clk);
            Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
            for (int i = 1; i <= 10; i++) begin
                @(negedge Clk);
                Start = (i == 3);
                MDOp  = 3'd0; A = 32'h11111111; B = 32'h3;
                RdSel = 1'b0;
                #1 chk("ign_busy", 32'(Busy), 32'd1);
                chk("ign_hold", Out, m_lo);
            end
            @(negedge Clk);
            Start = 1'b0;
            m_hi = nh;
            m_lo = nl;
            #1 chk("ign_done", 32'(Busy), 32'd0);
            chk_out("ign");
            repeat (6) begin
                @(negedge Clk);
                #1 chk("ign_nomult", 32'(Busy), 32'd0);
            end
            chk_out("ign_after");
        end

        // Reset in the middle of a multiply.
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'd0; A = 32'd9; B = 32'd9;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1 chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk_out("mid_rst");
        @(negedge Clk);
        Reset = 1'b1;
        repeat (8) begin
            @(negedge Clk);
            #1 chk("post_rst_busy", 32'(Busy), 32'd0);
        end
        chk_out("post_rst");

        for (int k = 0; k < 40; k++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(7, 0));
            a  = $urandom;
            b  = ($urandom_range(5, 0) == 0) ? 32'd0 :
                 ($urandom_range(1, 0) == 1) ? 32'($urandom_range(20, 0) - 10) :
                 $urandom;
            do_op(op, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
